// File: rtl/if_fetch_queue_pkg.sv
// Shared types and constants for the instruction fetch queue.
// These constants mirror the core's common defines header
// (RstEnable, ChipEnable, ZeroWord, InstAddrBus, InstBus).
package if_fetch_queue_pkg;

    localparam logic RST_ENABLE  = 1'b1;
    localparam logic CHIP_ENABLE = 1'b1;
    localparam int   INST_ADDR_W = 32;
    localparam int   INST_W      = 32;

    typedef logic [INST_ADDR_W-1:0] inst_addr_t;
    typedef logic [INST_W-1:0]      inst_t;

    localparam inst_addr_t ZERO_WORD = '0;

    // One buffered fetch: the PC and the instruction read at that PC.
    typedef struct packed {
        inst_addr_t pc;
        inst_t      inst;
    } fetch_entry_t;

endpackage

// File: rtl/if_fetch_queue_if.sv
// Fetch-queue bus: the PC/ROM side, the flush input and the decode handshake.
// master = PC register + decode stage, slave = the fetch queue.
interface if_fetch_queue_if;
    import if_fetch_queue_pkg::*;

    inst_addr_t  pc_i;
    logic        ce_i;
    inst_t       inst_i;
    logic        stall_req_o;
    logic        flush_i;
    logic        id_valid_o;
    logic        id_ready_i;
    inst_addr_t  id_pc_o;
    inst_t       id_inst_o;
    logic [31:0] stall_cnt_o;

    modport master (
        output pc_i, ce_i, inst_i, flush_i, id_ready_i,
        input  stall_req_o, id_valid_o, id_pc_o, id_inst_o, stall_cnt_o
    );

    modport slave (
        input  pc_i, ce_i, inst_i, flush_i, id_ready_i,
        output stall_req_o, id_valid_o, id_pc_o, id_inst_o, stall_cnt_o
    );

endinterface

// File: rtl/if_fetch_queue_mem.sv
// DEPTH x {pc, inst} register file: one synchronous write port,
// one asynchronous read port. Pointer management lives in the parent.
module if_fetch_queue_mem
    import if_fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         i_we,
    input  logic [AW-1:0] i_waddr,
    input  fetch_entry_t i_wdata,
    input  logic [AW-1:0] i_raddr,
    output fetch_entry_t o_rdata
);

    fetch_entry_t r_mem [DEPTH];

    // Capture the incoming fetch at the write pointer.
    // NOTE: storage is deliberately not reset; an entry is only ever read after it
    // was written, since the parent's count gates id_valid_o and forces zero data.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction fetch queue between the PC/ROM stage and the IF/ID register.
// Buffers up to DEPTH {pc, inst} pairs, presents them in order through a
// valid/ready handshake, stalls the PC register when full and drops all
// entries on flush. Synchronous active-high reset dominates flush.
// Optional feature macro: IF_FETCH_QUEUE_STATS_EN builds a saturating
// count of stalled cycles on stall_cnt_o; otherwise that port is tied to 0.
module if_fetch_queue
    import if_fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    if_fetch_queue_if.slave  bus
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [AW:0]   r_count;

    logic          w_rst;
    logic          w_full;
    logic          w_empty;
    logic          w_enq;
    logic          w_deq;
    fetch_entry_t  w_wdata;
    fetch_entry_t  w_rdata;

    assign w_rst   = (rst == RST_ENABLE);
    assign w_full  = (r_count == FULL_COUNT);
    assign w_empty = (r_count == '0);

    // Stall depends on registered count only, so there is no input-to-stall path.
    assign bus.stall_req_o = w_full;

    assign w_enq = (bus.ce_i == CHIP_ENABLE) && !w_full && !bus.flush_i && !w_rst;
    assign w_deq = !w_empty && bus.id_ready_i && !bus.flush_i && !w_rst;

    assign w_wdata = '{pc: bus.pc_i, inst: bus.inst_i};

    if_fetch_queue_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_enq),
        .i_waddr (r_wp),
        .i_wdata (w_wdata),
        .i_raddr (r_rp),
        .o_rdata (w_rdata)
    );

    // Pointer and occupancy update; reset beats flush, flush beats the handshake.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order within the block.
    always_ff @(posedge clk) begin
        if (w_rst) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else if (bus.flush_i) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            if (w_enq) begin
                r_wp <= r_wp + 1'b1;
            end
            if (w_deq) begin
                r_rp <= r_rp + 1'b1;
            end
            r_count <= r_count + (AW + 1)'(w_enq) - (AW + 1)'(w_deq);
        end
    end

    assign bus.id_valid_o = !w_empty;
    assign bus.id_pc_o    = w_empty ? ZERO_WORD : w_rdata.pc;
    assign bus.id_inst_o  = w_empty ? ZERO_WORD : w_rdata.inst;

`ifdef IF_FETCH_QUEUE_STATS_EN
    logic [31:0] r_stall_cnt;

    // Count stalled cycles, saturating; only reset clears it, flush does not.
    always_ff @(posedge clk) begin
        if (w_rst) begin
            r_stall_cnt <= '0;
        end else if (w_full && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign bus.stall_cnt_o = r_stall_cnt;
`else
    assign bus.stall_cnt_o = 32'h0;
`endif

endmodule
